// File: rtl/seq_gen_1010_tx.sv
// seq_gen_1010_tx: serial frame transmitter sending sync word, payload (MSB first) and an idle gap, paced by bit_en.
module seq_gen_1010_tx #(
  parameter logic [3:0] SYNC_WORD  = 4'b1010,
  parameter int         SYNC_LEN   = 4,
  parameter int         DATA_W     = 8,
  parameter int         GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              x_out,
  output logic              sync_active,
  output logic              busy,
  output logic              frame_done
);
  localparam int MAXL = (SYNC_LEN > DATA_W) ? ((SYNC_LEN > GAP_CYCLES) ? SYNC_LEN : GAP_CYCLES)
                                            : ((DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES);
  localparam int CW = $clog2(MAXL) + 1;
  localparam int FW = SYNC_LEN + DATA_W;
  localparam logic [SYNC_LEN-1:0] SYNC_BITS = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [CW-1:0] LAST_S = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] LAST_D = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_G = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] sh, sh_n;
  logic x_n, sync_n, busy_n, done_n;
  assign ready = (state == IDLE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      x_out       <= 1'b0;
      sync_active <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sh          <= sh_n;
      x_out       <= x_n;
      sync_active <= sync_n;
      busy        <= busy_n;
      frame_done  <= done_n;
    end
  // Sync word and payload share one shift register; the MSB is always the next line bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    x_n     = x_out;
    sync_n  = sync_active;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        x_n    = 1'b0;
        sync_n = 1'b0;
        if (valid) begin
          sh_n    = {SYNC_BITS, data_in};
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SYNC;
        end
      end
      SYNC: if (bit_en) begin
        x_n    = sh[FW-1];
        sh_n   = sh << 1;
        sync_n = 1'b1;
        cnt_n  = (cnt == LAST_S) ? '0 : cnt + 1'b1;
        state_n = (cnt == LAST_S) ? DATA : SYNC;
      end
      DATA: if (bit_en) begin
        x_n    = sh[FW-1];
        sh_n   = sh << 1;
        sync_n = 1'b0;
        cnt_n  = (cnt == LAST_D) ? '0 : cnt + 1'b1;
        state_n = (cnt == LAST_D) ? GAP : DATA;
      end
      GAP: if (bit_en) begin
        x_n    = 1'b0;
        sync_n = 1'b0;
        cnt_n  = (cnt == LAST_G) ? '0 : cnt + 1'b1;
        if (cnt == LAST_G) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        x_n     = 1'b0;
        sync_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_seq_gen_1010_tx.sv
// tb_seq_gen_1010_tx: randomized and directed checks of seq_gen_1010_tx against a queue-based frame model.
module tb_seq_gen_1010_tx;
  logic clk = 0, rst = 0, bit_en = 0, valid = 0;
  logic [7:0] data_in = '0;
  logic ready, x_out, sync_active, busy, frame_done;
  int n_chk = 0, n_pass = 0;
  bit q[$];
  bit cap[$];
  logic m_x, m_sync, m_busy, m_done;
  int m_pos;
  logic [3:0] sw = 4'b1010;

  seq_gen_1010_tx dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .valid(valid), .data_in(data_in),
    .ready(ready), .x_out(x_out), .sync_active(sync_active), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic m_reset;
    q.delete();
    m_x = 0; m_sync = 0; m_busy = 0; m_done = 0; m_pos = 0;
  endtask

  // One clock: drive inputs, advance the frame model, then compare every output.
  task automatic step(input logic be, input logic v, input logic [7:0] d);
    bit popped;
    popped = 0;
    bit_en = be; valid = v; data_in = d;
    @(posedge clk);
    m_done = 0;
    if (!rst) m_reset();
    else if (!m_busy) begin
      if (v) begin
        for (int i = 3; i >= 0; i--) q.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) q.push_back(d[i]);
        repeat (2) q.push_back(1'b0);
        m_busy = 1; m_pos = 0;
      end
    end else if (be) begin
      m_x = q.pop_front();
      m_sync = (m_pos < 4);
      m_pos++;
      popped = 1;
      if (q.size() == 0) begin m_busy = 0; m_done = 1; end
    end
    @(negedge clk);
    if (popped) cap.push_back(x_out);
    chk("x_out", x_out, m_x);
    chk("sync_active", sync_active, m_sync);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("ready", ready, !m_busy);
  endtask

  function automatic logic [31:0] line_bits();
    logic [31:0] v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  function automatic int cnt1010(input bit ov);
    int n = 0, i = 0;
    while (i + 3 < cap.size()) begin
      if (cap[i] && !cap[i+1] && cap[i+2] && !cap[i+3]) begin n++; i += ov ? 1 : 4; end
      else i++;
    end
    return n;
  endfunction

  task automatic run_frame(input logic [7:0] d, input int per, input logic nag, output int edges, output int clks);
    int t = 0;
    cap.delete();
    step(1, 1, d);
    do begin
      step((t % per) == 0, nag, nag ? 8'hFF : d);
      t++;
    end while (!m_done && t < 400);
    chk("frame_timeout", m_done, 1);
    edges = cap.size();
    clks = t;
  endtask

  initial begin
    int e, c, nd, nm;
    m_reset();
    @(negedge clk);
    chk("rst_x", x_out, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    step(1, 1, 8'h77);
    rst = 1;
    step(0, 0, 8'h00);
    run_frame(8'hC3, 1, 0, e, c);
    chk("t1_line", line_bits(), 32'b10101100001100);
    chk("t1_edges", e, 14);
    chk("t1_det", cnt1010(1), 1);
    run_frame(8'h5A, 3, 0, e, c);
    chk("t2_line", line_bits(), 32'b10100101101000);
    chk("t2_clks", c, 13 * 3 + 1);
    run_frame(8'h3C, 2, 1, e, c);
    chk("t3_line", line_bits(), 32'b10100011110000);
    step(1, 0, 8'h00);
    cap.delete();
    step(1, 1, 8'h96);
    for (int t = 0; t < 50 && m_pos < 7; t++) step(1, 0, 8'h00);
    rst = 0;
    #1;
    chk("t4_x", x_out, 0);
    chk("t4_ready", ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_sync", sync_active, 0);
    step(1, 1, 8'h11);
    step(1, 0, 8'h00);
    rst = 1;
    run_frame(8'hC3, 1, 0, e, c);
    chk("t4_line", line_bits(), 32'b10101100001100);
    cap.delete();
    nd = 0; nm = 0;
    for (int t = 0; t < 100 && nm < 2; t++) begin
      step(1, 1, nm == 0 ? 8'hA5 : 8'h0F);
      nd += frame_done;
      nm += m_done;
    end
    step(1, 0, 8'h00);
    chk("t5_done", nd, 2);
    chk("t5_line", line_bits(), 32'b1010101001010010100000111100);
    run_frame(8'hAA, 1, 0, e, c);
    chk("t6_line", line_bits(), 32'b10101010101000);
    chk("t6_det", cnt1010(0), 3);
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 0;
        step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
        rst = 1;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
